// File: rtl/motor_pkg.sv
// Shared definitions for the stepper command path: FSM state encoding,
// default widths and the ramp period multiplier.
package motor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } estado_t;

   localparam int CNT_W_DEF   = 16;
   localparam int DIV_W_DEF   = 16;
   localparam int RAMP_FACTOR = 2;

endpackage

// File: rtl/gen_tick.sv
// Loadable down-counter that paces the step period. tc is a registered
// flag that is high exactly while the count sits at zero; with enable
// active the counter then reloads on the next edge. A reload value of 1
// therefore keeps tc high continuously.
module gen_tick #(
   parameter int W = 17
) (
   input  logic         clk_1,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] recarga,
   output logic         tc
);

   logic [W-1:0] cnt;

   // Count down one period; reload on explicit load or on wrap from zero.
   always_ff @(posedge clk_1 or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         tc  <= 1'b0;
      end else if (load || (en && cnt == '0)) begin
         cnt <= recarga - W'(1);
         tc  <= (recarga == W'(1));
      end else if (en) begin
         cnt <= cnt - W'(1);
         tc  <= (cnt == W'(1));
      end
   end

endmodule

// File: rtl/ctrl_motor.sv
// Step-command controller: accepts a move (step count, step period) and
// emits one single-cycle motor_activo pulse per step, with busy/done/abort
// status. Optional macro MOTOR_RAMP_EN runs the first RAMP_PASOS steps at
// RAMP_FACTOR times the commanded period.
module ctrl_motor
   import motor_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int DIV_W      = DIV_W_DEF,
   parameter int RAMP_PASOS = 4
) (
   input  logic             clk_1,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] pasos,
   input  logic [DIV_W-1:0] periodo,
   input  logic             parar,
   output logic             motor_activo,
   output logic             ocupado,
   output logic             listo,
   output logic             abortado,
   output logic [CNT_W-1:0] pasos_rest
);

   localparam int TW = DIV_W + 1;

`ifdef MOTOR_RAMP_EN
   localparam bit RAMP_ON = 1'b1;
`else
   localparam bit RAMP_ON = 1'b0;
`endif

   localparam logic [CNT_W-1:0] RAMP_INI = RAMP_ON ? CNT_W'(RAMP_PASOS) : '0;

   estado_t          estado;
   logic [DIV_W-1:0] per_q;
   logic [DIV_W-1:0] per_in;
   logic [DIV_W-1:0] per_sel;
   logic [CNT_W-1:0] ramp_rest;
   logic             rampa;
   logic [TW-1:0]    recarga;
   logic             tick_load;
   logic             tick_en;
   logic             tc;

   // Select the period for the step being timed: the incoming command when
   // loading from IDLE, otherwise the latched one; double it during the ramp.
   always_comb begin
      per_in    = (periodo == '0) ? DIV_W'(1) : periodo;
      per_sel   = (estado == IDLE) ? per_in : per_q;
      rampa     = (estado == IDLE) ? (RAMP_INI != '0) : (ramp_rest > CNT_W'(1));
      recarga   = rampa ? (TW'(per_sel) * TW'(RAMP_FACTOR)) : TW'(per_sel);
      tick_load = (estado == IDLE) && start && (pasos != '0);
      tick_en   = (estado == RUN);
   end

   gen_tick #(
      .W(TW)
   ) u_tick (
      .clk_1  (clk_1),
      .rst_n  (rst_n),
      .load   (tick_load),
      .en     (tick_en),
      .recarga(recarga),
      .tc     (tc)
   );

   // Command FSM with registered status/pulse outputs; parar overrides a
   // coinciding terminal count so that step is neither pulsed nor counted.
   always_ff @(posedge clk_1 or negedge rst_n) begin
      if (!rst_n) begin
         estado       <= IDLE;
         motor_activo <= 1'b0;
         ocupado      <= 1'b0;
         listo        <= 1'b0;
         abortado     <= 1'b0;
         pasos_rest   <= '0;
         per_q        <= '0;
         ramp_rest    <= '0;
      end else begin
         motor_activo <= 1'b0;
         listo        <= 1'b0;
         case (estado)
            IDLE: begin
               if (start) begin
                  pasos_rest <= pasos;
                  per_q      <= per_in;
                  ramp_rest  <= RAMP_INI;
                  abortado   <= 1'b0;
                  ocupado    <= 1'b1;
                  estado     <= (pasos == '0) ? FIN : RUN;
               end
            end
            RUN: begin
               if (parar) begin
                  abortado <= 1'b1;
                  estado   <= FIN;
               end else if (tc) begin
                  motor_activo <= 1'b1;
                  pasos_rest   <= pasos_rest - CNT_W'(1);
                  if (ramp_rest != '0) begin
                     ramp_rest <= ramp_rest - CNT_W'(1);
                  end
                  if (pasos_rest == CNT_W'(1)) begin
                     estado <= FIN;
                  end
               end
            end
            FIN: begin
               listo   <= 1'b1;
               ocupado <= 1'b0;
               estado  <= IDLE;
            end
            default: estado <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_motor.sv
// Directed bench for ctrl_motor. Each move is recorded cycle by cycle after
// the accepting edge E0 (index j = sample taken after edge E0+j).
module tb_ctrl_motor;

   localparam int CNT_W = 16;
   localparam int DIV_W = 16;
   localparam int RP    = 2;
   localparam int L     = 40;
`ifdef MOTOR_RAMP_EN
   localparam int RAMP_ON = 1;
`else
   localparam int RAMP_ON = 0;
`endif

   logic             clk_1 = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             parar = 1'b0;
   logic [CNT_W-1:0] pasos = '0;
   logic [DIV_W-1:0] periodo = '0;
   logic             motor_activo;
   logic             ocupado;
   logic             listo;
   logic             abortado;
   logic [CNT_W-1:0] pasos_rest;

   int npass = 0;
   int ntot  = 0;
   int m_fase = 0;

   logic [L-1:0] ma_v, li_v, oc_v, ab_v;
   int           pr_a [L];

   ctrl_motor #(
      .CNT_W     (CNT_W),
      .DIV_W     (DIV_W),
      .RAMP_PASOS(RP)
   ) dut (
      .clk_1       (clk_1),
      .rst_n       (rst_n),
      .start       (start),
      .pasos       (pasos),
      .periodo     (periodo),
      .parar       (parar),
      .motor_activo(motor_activo),
      .ocupado     (ocupado),
      .listo       (listo),
      .abortado    (abortado),
      .pasos_rest  (pasos_rest)
   );

   always #5 clk_1 = ~clk_1;

   // Downstream motor phase: advances on each edge that samples motor_activo high.
   always @(posedge clk_1) if (motor_activo === 1'b1) m_fase++;

   // Timing model: pulse vector, listo, ocupado, abortado for a command
   // (n steps, period p, parar sampled at edge ea; ea=0 means never).
   function automatic void model(input int n, input int p, input int ea,
                                 output logic [L-1:0] pv, output logic [L-1:0] lv,
                                 output logic [L-1:0] ov, output logic [L-1:0] av);
      int pe, t, fin;
      pe = (p == 0) ? 1 : p;
      t = 0; fin = 0; pv = '0; lv = '0; ov = '0; av = '0;
      for (int k = 1; k <= n; k++) begin
         t += (RAMP_ON != 0 && k <= RP) ? 2 * pe : pe;
         if (ea > 0 && t >= ea) begin
            fin = ea;
            for (int j = ea; j < L; j++) av[j] = 1'b1;
            break;
         end
         if (t < L) pv[t] = 1'b1;
         fin = t;
      end
      if (fin + 1 < L) lv[fin + 1] = 1'b1;
      for (int j = 0; j <= fin && j < L; j++) ov[j] = 1'b1;
   endfunction

   task automatic run_cmd(input int n, input int p, input int stop_at, input int restart_at);
      @(negedge clk_1);
      pasos = CNT_W'(n); periodo = DIV_W'(p); start = 1'b1;
      @(posedge clk_1);
      for (int j = 0; j < L; j++) begin
         @(negedge clk_1);
         start = 1'b0; parar = 1'b0;
         ma_v[j] = motor_activo; li_v[j] = listo; oc_v[j] = ocupado; ab_v[j] = abortado;
         pr_a[j] = int'(pasos_rest);
         if (j + 1 == stop_at) parar = 1'b1;
         if (j + 1 == restart_at) begin start = 1'b1; pasos = CNT_W'(9); end
      end
      start = 1'b0; parar = 1'b0;
   endtask

   task automatic test_reset();
      int f0;
      @(negedge clk_1);
      ntot++;
      if ({motor_activo, ocupado, listo, abortado} !== 4'b0000 || pasos_rest !== '0)
         $display("FAIL reset_hold: got ma=%b oc=%b li=%b ab=%b pr=%0d expected all 0",
                  motor_activo, ocupado, listo, abortado, pasos_rest);
      else npass++;
      f0 = m_fase;
      @(negedge clk_1); rst_n = 1'b1;
      repeat (4) @(negedge clk_1);
      ntot++;
      if ({motor_activo, ocupado, listo, abortado} !== 4'b0000 || pasos_rest !== '0)
         $display("FAIL reset_release: got ma=%b oc=%b li=%b ab=%b pr=%0d expected all 0",
                  motor_activo, ocupado, listo, abortado, pasos_rest);
      else npass++;
      ntot++;
      if (m_fase !== f0) $display("FAIL reset_phase: got %0d expected %0d", m_fase, f0);
      else npass++;
   endtask

   task automatic test_move();
      logic [L-1:0] pv, lv, ov, av;
      int li_idx, bad;
      model(5, 3, 0, pv, lv, ov, av);
      run_cmd(5, 3, 0, 0);
      ntot++;
      if (ma_v !== pv) $display("FAIL move_pulses: got %b expected %b", ma_v, pv);
      else npass++;
      li_idx = -1;
      for (int j = 0; j < L; j++) if (li_v[j] && li_idx < 0) li_idx = j;
      ntot++;
      if (li_idx !== (RAMP_ON != 0 ? 22 : 16))
         $display("FAIL move_listo: got %0d expected %0d", li_idx, (RAMP_ON != 0 ? 22 : 16));
      else npass++;
      ntot++;
      if (oc_v !== ov) $display("FAIL move_ocupado: got %b expected %b", oc_v, ov);
      else npass++;
      bad = -1;
      for (int j = 0, c = 5; j < L; j++) begin
         if (pv[j]) c--;
         if (pr_a[j] !== c && bad < 0) bad = j;
      end
      ntot++;
      if (bad >= 0) $display("FAIL move_pasos_rest: at j=%0d got %0d", bad, pr_a[bad]);
      else npass++;
      ntot++;
      if (pr_a[0] !== 5 || pr_a[L-1] !== 0)
         $display("FAIL move_rest_ends: got %0d..%0d expected 5..0", pr_a[0], pr_a[L-1]);
      else npass++;
   endtask

   task automatic test_abort();
      logic [L-1:0] pv, lv, ov, av;
      model(10, 2, 7, pv, lv, ov, av);
      run_cmd(10, 2, 7, 0);
      ntot++;
      if (ma_v !== pv) $display("FAIL abort_pulses: got %b expected %b", ma_v, pv);
      else npass++;
      ntot++;
      if (li_v !== lv) $display("FAIL abort_listo: got %b expected %b", li_v, lv);
      else npass++;
      ntot++;
      if (ab_v !== av) $display("FAIL abort_flag: got %b expected %b", ab_v, av);
      else npass++;
      ntot++;
      if (pr_a[L-1] !== (RAMP_ON != 0 ? 9 : 7))
         $display("FAIL abort_rest: got %0d expected %0d", pr_a[L-1], (RAMP_ON != 0 ? 9 : 7));
      else npass++;
      run_cmd(1, 1, 0, 0);
      ntot++;
      if (ab_v[0] !== 1'b0 || ab_v[L-1] !== 1'b0)
         $display("FAIL abort_clear: got %b/%b expected 0/0", ab_v[0], ab_v[L-1]);
      else npass++;
   endtask

   task automatic test_zero();
      int f0;
      f0 = m_fase;
      run_cmd(0, 5, 0, 0);
      ntot++;
      if (ma_v !== '0 || m_fase !== f0) $display("FAIL zero_pulses: got %b expected none", ma_v);
      else npass++;
      ntot++;
      if (li_v[1] !== 1'b1 || li_v[0] !== 1'b0 || li_v[2] !== 1'b0)
         $display("FAIL zero_listo: got %b expected bit 1 only", li_v[2:0]);
      else npass++;
      ntot++;
      if (oc_v[0] !== 1'b1 || oc_v[1] !== 1'b0)
         $display("FAIL zero_ocupado: got %b expected 01", oc_v[1:0]);
      else npass++;
   endtask

   task automatic test_back_to_back();
      logic [L-1:0] pv, lv, ov, av;
      int f0;
      model(4, 2, 0, pv, lv, ov, av);
      f0 = m_fase;
      run_cmd(4, 2, 0, 3);
      ntot++;
      if (ma_v !== pv) $display("FAIL restart_pulses: got %b expected %b", ma_v, pv);
      else npass++;
      ntot++;
      if (m_fase - f0 !== 4) $display("FAIL restart_count: got %0d expected 4", m_fase - f0);
      else npass++;
      ntot++;
      if (li_v !== lv) $display("FAIL restart_listo: got %b expected %b", li_v, lv);
      else npass++;
   endtask

   task automatic test_period_zero();
      logic [L-1:0] pv, lv, ov, av;
      model(3, 0, 0, pv, lv, ov, av);
      run_cmd(3, 0, 0, 0);
      ntot++;
      if (ma_v !== pv) $display("FAIL p0_pulses: got %b expected %b", ma_v, pv);
      else npass++;
      ntot++;
      if (li_v !== lv) $display("FAIL p0_listo: got %b expected %b", li_v, lv);
      else npass++;
   endtask

   task automatic test_reset_mid();
      int seen;
      @(negedge clk_1);
      pasos = CNT_W'(10); periodo = DIV_W'(2); start = 1'b1;
      @(negedge clk_1); start = 1'b0;
      repeat (4) @(negedge clk_1);
      ntot++;
      if (ocupado !== 1'b1) $display("FAIL rstmid_busy: got %b expected 1", ocupado);
      else npass++;
      #2 rst_n = 1'b0;
      #1;
      ntot++;
      if ({motor_activo, ocupado, listo, abortado} !== 4'b0000 || pasos_rest !== '0)
         $display("FAIL rstmid_async: got ma=%b oc=%b li=%b ab=%b pr=%0d expected all 0",
                  motor_activo, ocupado, listo, abortado, pasos_rest);
      else npass++;
      seen = 0;
      repeat (2) @(negedge clk_1) if (listo !== 1'b0) seen++;
      rst_n = 1'b1;
      repeat (10) @(negedge clk_1) if (listo !== 1'b0 || ocupado !== 1'b0) seen++;
      ntot++;
      if (seen !== 0) $display("FAIL rstmid_no_listo: got %0d active cycles expected 0", seen);
      else npass++;
   endtask

   initial begin
      test_reset();
      test_move();
      test_abort();
      test_zero();
      test_back_to_back();
      test_period_zero();
      test_reset_mid();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/ctrl_motor.md
# ctrl_motor

Step-command controller placed directly upstream of the stepper `motor` stage. It accepts a move command: a step count and a step period in `clk_1` cycles. It then drives `motor_activo` as exactly one single-cycle pulse per step. The downstream `motor` advances its phase output `M` by one phase on every `clk_1` edge that samples `motor_activo` high. Busy, done and abort status go back to the command source, which is a UI/FSM.

## Interface
- `CNT_W`, default 16: width of the step count and the remaining-step counter.
- `DIV_W`, default 16: width of the step period.
- `RAMP_PASOS`, default 4: number of initial steps run at the slow ramp period. Used only with `MOTOR_RAMP_EN`.
- `clk_1`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe. Accepted only in IDLE.
- `pasos`  in  CNT_W  step count N, sampled when `start` is accepted.
- `periodo`  in  DIV_W  step period P in cycles, sampled when `start` is accepted. A value of 0 is treated as 1.
- `parar`  in  1  abort request. Effective only in RUN.
- `motor_activo`  out  1  step pulse to `motor`, registered, one cycle wide.
- `ocupado`  out  1  high while a command is executing.
- `listo`  out  1  one-cycle completion pulse, for both normal end and abort.
- `abortado`  out  1  set when a move ends by `parar`. Held until the next accepted `start`.
- `pasos_rest`  out  CNT_W  steps not yet issued.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - If `start` is high: latch N and P, load `pasos_rest`=N, clear `abortado`.
  - If N=0, go to FIN. No step pulse is emitted.
  - Otherwise go to RUN and load the tick counter.
- RUN:
  - The tick counter counts P cycles per step.
  - At terminal count: `motor_activo` is high for one cycle, `pasos_rest` decrements, and the counter reloads.
  - When `pasos_rest` reaches 0, go to FIN.
- FIN: `listo` is high for one cycle, `ocupado` drops, then go to IDLE.
- `start` is ignored while `ocupado` is high. No queueing.
- `parar` sampled high in RUN:
  - Go to FIN. No further pulses.
  - `abortado` is set to 1.
  - `pasos_rest` freezes at the count of unissued steps.
- Simultaneous `parar` and a terminal count: `parar` wins. That pulse is suppressed and is not decremented.
- `parar` in IDLE or FIN has no effect.
- The tick counter is DIV_W+1 bits wide so that the doubled ramp period never overflows.

## Timing
- Reset values: `motor_activo`=0, `ocupado`=0, `listo`=0, `abortado`=0, `pasos_rest`=0, state IDLE.
- Reset mid-move clears all outputs immediately (asynchronously). No `listo` is produced.
- Let E0 be the edge at which `start` is accepted:
  - `ocupado` is high after E0.
  - Step pulse k (1..N) is high in the cycle after edge E0+k·P.
  - `listo` is high after edge E0+N·P+1.
  - `ocupado` is low after that same edge.
- N=0: `listo` is high after E0+1. `ocupado` is high for one cycle only.
- `parar` sampled at edge Ea: `listo` is high after Ea+1 and no pulse is emitted at or after Ea.
- The step rate holds for any P ≥ 1. With P=1, `motor_activo` stays high for N consecutive cycles.

## Configuration
- Macro: `MOTOR_RAMP_EN`.
- Defined: the first min(`RAMP_PASOS`, N) steps use period 2·P, and the remaining steps use P.
- Not defined: every step uses P, and `RAMP_PASOS` is unused.
- Both builds keep identical ports and reset behaviour.

## Structure
- Shared package `motor_pkg` holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, FIN=2'd2);
  - default `CNT_W`/`DIV_W` constants;
  - the ramp factor constant (2).
- One sub-module, `gen_tick`:
  - loadable down-counter with enable;
  - reload value input;
  - registered one-cycle terminal-count output.
- `ctrl_motor` holds the FSM, the step counter and the ramp selection.

## Test plan
- Reset held low, then released:
  - all outputs are 0 in both builds;
  - `motor` `M` does not advance while `motor_activo` stays 0.
- N=5, P=3, macro off:
  - exactly 5 single-cycle pulses, 3 cycles apart, first after E0+3;
  - `listo` after E0+16;
  - `pasos_rest` counts 5→0.
- N=5, P=3, `MOTOR_RAMP_EN` with `RAMP_PASOS`=2:
  - pulses after E0+6, +12, +15, +18, +21;
  - `listo` after E0+22.
- N=10, P=2, `parar` pulsed at E0+7:
  - 3 pulses issued;
  - `listo` after E0+8;
  - `abortado`=1 and `pasos_rest`=7;
  - a second `start` clears `abortado`.
- N=0:
  - no pulse;
  - `listo` after E0+1.
- `start` re-pulsed mid-move: ignored, and the pulse count still equals the original N.
- `rst_n` asserted mid-move: all outputs 0 immediately and no `listo`.
